// File: rtl/prim_pad_wrapper_pkg.sv
// Shared pad types, attribute layout and sequencer state encoding for the
// pad attribute controller.
package prim_pad_wrapper_pkg;

  localparam int unsigned AttrDw = 8;

  typedef enum logic [1:0] {
    InputStd = 2'd0,
    BidirStd = 2'd1,
    BidirOd  = 2'd2,
    AnalogIn = 2'd3
  } pad_type_e;

  typedef struct packed {
    logic       invert;
    logic       pull_en;
    logic       pull_sel;
    logic       keeper_en;
    logic [1:0] drive_strength;
    logic [1:0] slew;
  } pad_attr_t;

  typedef enum logic [1:0] {
    SeqIdle,
    SeqGate,
    SeqSettle
  } seq_state_e;

  // Open-drain pads have no push-pull drive, so the strength field is meaningless.
  function automatic pad_attr_t eff_attr(input pad_type_e pad_type, input pad_attr_t attr);
    pad_attr_t res;
    res = attr;
    if (pad_type == BidirOd) res.drive_strength = '0;
    return res;
  endfunction

endpackage

// File: rtl/pad_attr_seq.sv
// Gate/settle sequencer: holds the output-enable gate for one Gate cycle plus
// SettleCycles cycles around each attribute change.
module pad_attr_seq
  import prim_pad_wrapper_pkg::*;
#(
  parameter int unsigned SettleCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic ready_o,
  output logic busy_o,
  output logic apply_o
);

  localparam int unsigned CntW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;

  seq_state_e      state;
  logic [CntW-1:0] cnt;

  // ready_o is a register (not a decode of Idle) so it stays low during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= SeqIdle;
      cnt     <= '0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        SeqIdle: begin
          ready_o <= 1'b1;
          if (start_i) begin
            state   <= SeqGate;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        SeqGate: begin
          if (SettleCycles == 0) begin
            state   <= SeqIdle;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            state <= SeqSettle;
            cnt   <= CntW'(SettleCycles);
          end
        end
        SeqSettle: begin
          if (cnt <= CntW'(1)) begin
            state   <= SeqIdle;
            cnt     <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: begin
          state   <= SeqIdle;
          cnt     <= '0;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  assign apply_o = (state == SeqGate);

endmodule

// File: rtl/pad_attr_ctrl.sv
// Per-pad attribute registers with write decode; each real change is applied
// under an output-enable gate sequenced by pad_attr_seq.
module pad_attr_ctrl
  import prim_pad_wrapper_pkg::*;
#(
  parameter int unsigned NumPads      = 8,
  parameter pad_type_e   PadType      = BidirStd,
  parameter int unsigned SettleCycles = 4,
  parameter pad_attr_t   ResetAttr    = '0,
  localparam int unsigned IdxW        = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [IdxW-1:0]             wr_idx_i,
  input  logic [AttrDw-1:0]           wr_attr_i,
  output logic [NumPads*AttrDw-1:0]   attr_o,
  output logic [NumPads-1:0]          oe_gate_o,
  output logic                        busy_o,
  output logic                        err_o
);

  pad_attr_t       attr_q [NumPads];
  pad_attr_t       pend_q;
  logic [IdxW-1:0] idx_q;
  logic            err_q;

  logic            ready, busy, apply;
  logic            accept, idx_ok, reject, changed, start;
  logic [IdxW-1:0] rd_idx;
  pad_attr_t       wr_eff, cur_attr;

  always_comb begin
    accept   = wr_valid_i & ready;
    idx_ok   = 32'(wr_idx_i) < NumPads;
    reject   = !idx_ok || (PadType == AnalogIn);
    wr_eff   = eff_attr(PadType, pad_attr_t'(wr_attr_i));
    rd_idx   = idx_ok ? wr_idx_i : '0;
    cur_attr = attr_q[rd_idx];
    changed  = (wr_eff != cur_attr);
    start    = accept & !reject & changed;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumPads; i++) attr_q[i] <= ResetAttr;
      pend_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept & reject;
      if (start) begin
        idx_q  <= wr_idx_i;
        pend_q <= wr_eff;
      end
      if (apply) attr_q[idx_q] <= pend_q;
    end
  end

  pad_attr_seq #(
    .SettleCycles(SettleCycles)
  ) u_seq (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start),
    .ready_o(ready),
    .busy_o (busy),
    .apply_o(apply)
  );

  always_comb begin
    for (int unsigned i = 0; i < NumPads; i++) attr_o[i*AttrDw +: AttrDw] = attr_q[i];
    oe_gate_o = '0;
    if (busy) oe_gate_o[idx_q] = 1'b1;
  end

  assign wr_ready_o = ready;
  assign busy_o     = busy;
  assign err_o      = err_q;

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Directed bench: three instances cover standard, open-drain/zero-settle and
// analog configurations against hand-computed expectations.
module tb_pad_attr_ctrl;
  import prim_pad_wrapper_pkg::*;

  logic clk, rst_n;
  int   checks, failures;

  logic        m_valid, m_ready, m_busy, m_err;
  logic [2:0]  m_idx;
  logic [7:0]  m_attr_in, m_gate;
  logic [63:0] m_attr;

  logic        o_valid, o_ready, o_busy, o_err;
  logic [2:0]  o_idx;
  logic [7:0]  o_attr_in;
  logic [5:0]  o_gate;
  logic [47:0] o_attr;

  logic        a_valid, a_ready, a_busy, a_err;
  logic [1:0]  a_idx;
  logic [7:0]  a_attr_in;
  logic [3:0]  a_gate;
  logic [31:0] a_attr;

  pad_attr_ctrl #(.NumPads(8), .PadType(BidirStd), .SettleCycles(4)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(m_valid), .wr_ready_o(m_ready),
    .wr_idx_i(m_idx), .wr_attr_i(m_attr_in), .attr_o(m_attr), .oe_gate_o(m_gate),
    .busy_o(m_busy), .err_o(m_err));

  pad_attr_ctrl #(.NumPads(6), .PadType(BidirOd), .SettleCycles(0), .ResetAttr(8'h5A)) u_od (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(o_valid), .wr_ready_o(o_ready),
    .wr_idx_i(o_idx), .wr_attr_i(o_attr_in), .attr_o(o_attr), .oe_gate_o(o_gate),
    .busy_o(o_busy), .err_o(o_err));

  pad_attr_ctrl #(.NumPads(4), .PadType(AnalogIn), .SettleCycles(2)) u_an (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(a_valid), .wr_ready_o(a_ready),
    .wr_idx_i(a_idx), .wr_attr_i(a_attr_in), .attr_o(a_attr), .oe_gate_o(a_gate),
    .busy_o(a_busy), .err_o(a_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    m_valid = 0; m_idx = '0; m_attr_in = '0;
    o_valid = 0; o_idx = '0; o_attr_in = '0;
    a_valid = 0; a_idx = '0; a_attr_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(m_ready), 64'd0);
    check_eq("rst_attr", m_attr, 64'd0);
    check_eq("rst_gate", 64'(m_gate), 64'd0);
    check_eq("rst_busy_err", {m_busy, m_err}, 64'd0);
    check_eq("rst_od_attr", 64'(o_attr), 64'h5A5A_5A5A_5A5A);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", {m_ready, o_ready, a_ready}, 64'b111);
    check_eq("rel_gate", 64'(m_gate), 64'd0);

    // idx 3 <- 0x15 with 4 settle cycles
    m_valid = 1; m_idx = 3'd3; m_attr_in = 8'h15;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_eq($sformatf("a_gate%0d", k), 64'(m_gate), (k <= 5) ? 64'h08 : 64'h00);
      check_eq($sformatf("a_busy%0d", k), 64'(m_busy), (k <= 5) ? 64'd1 : 64'd0);
      check_eq($sformatf("a_ready%0d", k), 64'(m_ready), (k >= 6) ? 64'd1 : 64'd0);
      check_eq($sformatf("a_attr%0d", k), m_attr, (k >= 2) ? 64'h0000_0000_1500_0000 : 64'd0);
      if (k == 1) m_valid = 0;
    end

    // Same value again: no-op
    m_valid = 1;
    @(negedge clk);
    m_valid = 0;
    check_eq("noop_gate", 64'(m_gate), 64'd0);
    check_eq("noop_busy_err", {m_busy, m_err}, 64'd0);
    check_eq("noop_ready", 64'(m_ready), 64'd1);

    // Back-to-back: second request stalls until Idle
    m_valid = 1; m_idx = 3'd1; m_attr_in = 8'hA5;
    @(negedge clk);
    check_eq("b_gate1", 64'(m_gate), 64'h02);
    m_idx = 3'd6; m_attr_in = 8'h3C;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      check_eq($sformatf("b_ready%0d", k), 64'(m_ready), (k == 6) ? 64'd1 : 64'd0);
      check_eq($sformatf("b_gate%0d", k), 64'(m_gate),
               (k <= 5) ? 64'h02 : ((k == 6) ? 64'h00 : 64'h40));
    end
    m_valid = 0;
    repeat (5) @(negedge clk);
    check_eq("b_gate_end", 64'(m_gate), 64'd0);
    check_eq("b_attr", m_attr, 64'h003C_0000_1500_A500);

    // Open-drain, 6 pads, zero settle: out-of-range index rejected
    o_valid = 1; o_idx = 3'd7; o_attr_in = 8'hFF;
    @(negedge clk);
    o_valid = 0;
    check_eq("od_err", 64'(o_err), 64'd1);
    check_eq("od_err_busy", {o_busy, 6'(o_gate)}, 64'd0);
    @(negedge clk);
    check_eq("od_err_pulse", 64'(o_err), 64'd0);
    check_eq("od_err_attr", 64'(o_attr), 64'h5A5A_5A5A_5A5A);

    // Drive strength forced to 0; gate high exactly one cycle
    o_valid = 1; o_idx = 3'd2; o_attr_in = 8'hCF;
    @(negedge clk);
    o_valid = 0;
    check_eq("od_gate1", 64'(o_gate), 64'h04);
    check_eq("od_attr_old", 64'(o_attr), 64'h5A5A_5A5A_5A5A);
    @(negedge clk);
    check_eq("od_gate2", 64'(o_gate), 64'h00);
    check_eq("od_attr_new", 64'(o_attr), 64'h5A5A_5AC3_5A5A);
    check_eq("od_ready", 64'(o_ready), 64'd1);
    o_valid = 1;
    @(negedge clk);
    o_valid = 0;
    check_eq("od_noop", {o_busy, o_err, 6'(o_gate)}, 64'd0);

    // Analog pads reject every write
    a_valid = 1; a_idx = 2'd0; a_attr_in = 8'hFF;
    @(negedge clk);
    a_valid = 0;
    check_eq("an_err", 64'(a_err), 64'd1);
    check_eq("an_attr", 64'(a_attr), 64'd0);
    check_eq("an_gate", {a_busy, 4'(a_gate)}, 64'd0);
    @(negedge clk);
    check_eq("an_err_pulse", 64'(a_err), 64'd0);

    // Reset mid-Settle aborts the pending update
    m_valid = 1; m_idx = 3'd5; m_attr_in = 8'h77;
    @(negedge clk);
    m_valid = 0;
    repeat (2) @(negedge clk);
    check_eq("r_gate_settle", 64'(m_gate), 64'h20);
    #2 rst_n = 1'b0;
    #1;
    check_eq("r_gate", 64'(m_gate), 64'd0);
    check_eq("r_attr", m_attr, 64'd0);
    check_eq("r_busy_ready", {m_busy, m_ready, m_err}, 64'd0);
    check_eq("r_od_attr", 64'(o_attr), 64'h5A5A_5A5A_5A5A);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("r_rel_ready", 64'(m_ready), 64'd1);
    check_eq("r_rel_attr", m_attr, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
